// File: rtl/yarvi_loader_arb.sv
// Write-port arbiter between the core's ME stage and an external program loader.
// It freezes the core, drains in-flight stores, grants the loader, then restarts the core at a new PC.
module yarvi_loader_arb #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MASK_W       = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] core_address,
  input  logic [DATA_W-1:0] core_writedata,
  input  logic [MASK_W-1:0] core_writemask,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_address,
  input  logic [DATA_W-1:0] ld_writedata,
  input  logic [MASK_W-1:0] ld_writemask,
  output logic              ld_ack,
  input  logic              ld_release,
  input  logic [ADDR_W-1:0] ld_restart_pc,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [MASK_W-1:0] mem_writemask,
  output logic              freeze,
  output logic              restart,
  output logic [ADDR_W-1:0] restart_pc,
  output logic              loader_owns
);

  typedef enum logic [1:0] {
    ST_CORE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOADER = 2'd2,
    ST_RESUME = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [3:0]        drain_cnt_reg, drain_cnt_next;
  logic              freeze_reg;
  logic              ld_ack_reg;
  logic              restart_reg;
  logic [ADDR_W-1:0] restart_pc_reg;
  logic              loader_owns_reg;

  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    case (state_reg)
      ST_CORE: begin
        if (ld_req) begin
          state_next     = ST_DRAIN;
          drain_cnt_next = 4'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_reg == 4'd0) begin
          state_next = ST_LOADER;
        end else begin
          drain_cnt_next = drain_cnt_reg - 4'd1;
        end
      end
      ST_LOADER: begin
        if (ld_release) begin
          state_next = ST_RESUME;
        end
      end
      ST_RESUME: begin
        state_next = ST_CORE;
      end
      default: begin
        state_next = ST_CORE;
      end
    endcase
  end

  // Core keeps the port through DRAIN so stores already past EX still land.
  always_comb begin
    mem_address   = core_address;
    mem_writedata = core_writedata;
    mem_writemask = core_writemask;
    case (state_reg)
      ST_LOADER: begin
        mem_address   = ld_address;
        mem_writedata = ld_writedata;
        mem_writemask = ld_req ? ld_writemask : '0;
      end
      ST_RESUME: begin
        mem_writemask = '0;
      end
      default: begin
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= ST_CORE;
      drain_cnt_reg   <= 4'd0;
      freeze_reg      <= 1'b0;
      ld_ack_reg      <= 1'b0;
      restart_reg     <= 1'b0;
      restart_pc_reg  <= '0;
      loader_owns_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      drain_cnt_reg   <= drain_cnt_next;
      freeze_reg      <= (state_next != ST_CORE);
      loader_owns_reg <= (state_next == ST_LOADER);
      restart_reg     <= (state_next == ST_RESUME);
      ld_ack_reg      <= (state_reg == ST_LOADER) && ld_req;
      if ((state_reg == ST_LOADER) && ld_release) begin
        restart_pc_reg <= ld_restart_pc;
      end
    end
  end

  assign freeze      = freeze_reg;
  assign ld_ack      = ld_ack_reg;
  assign restart     = restart_reg;
  assign restart_pc  = restart_pc_reg;
  assign loader_owns = loader_owns_reg;

endmodule

// File: tb/tb_yarvi_loader_arb.sv
// Directed bench for yarvi_loader_arb; loader acks are tracked through a queue of due cycles.
module tb_yarvi_loader_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] core_address;
  logic [31:0] core_writedata;
  logic [3:0]  core_writemask;
  logic        ld_req;
  logic [31:0] ld_address;
  logic [31:0] ld_writedata;
  logic [3:0]  ld_writemask;
  logic        ld_ack;
  logic        ld_release;
  logic [31:0] ld_restart_pc;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_writemask;
  logic        freeze;
  logic        restart;
  logic [31:0] restart_pc;
  logic        loader_owns;

  int checks = 0;
  int errors = 0;
  int cycle_no = 0;
  int ack_q[$];

  always #5 clock = ~clock;

  yarvi_loader_arb #(
    .ADDR_W(32), .DATA_W(32), .MASK_W(4), .DRAIN_CYCLES(3)
  ) dut (
    .clock(clock), .reset(reset),
    .core_address(core_address), .core_writedata(core_writedata), .core_writemask(core_writemask),
    .ld_req(ld_req), .ld_address(ld_address), .ld_writedata(ld_writedata), .ld_writemask(ld_writemask),
    .ld_ack(ld_ack), .ld_release(ld_release), .ld_restart_pc(ld_restart_pc),
    .mem_address(mem_address), .mem_writedata(mem_writedata), .mem_writemask(mem_writemask),
    .freeze(freeze), .restart(restart), .restart_pc(restart_pc), .loader_owns(loader_owns)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle_no, obs, exp);
    end
  endtask

  task automatic chk_mem(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    chk("mem_writemask", {28'd0, mem_writemask}, {28'd0, mask});
    if (mask != 4'd0) begin
      chk("mem_address", mem_address, addr);
      chk("mem_writedata", mem_writedata, data);
    end
  endtask

  task automatic chk_ctl(input logic f, input logic r, input logic lo, input logic [31:0] pc);
    chk("freeze", {31'd0, freeze}, {31'd0, f});
    chk("restart", {31'd0, restart}, {31'd0, r});
    chk("loader_owns", {31'd0, loader_owns}, {31'd0, lo});
    chk("restart_pc", restart_pc, pc);
  endtask

  task automatic idle_inputs();
    core_writemask = 4'd0;
    core_address   = 32'h0;
    core_writedata = 32'h0;
    ld_req         = 1'b0;
    ld_writemask   = 4'd0;
    ld_release     = 1'b0;
    ld_restart_pc  = 32'h0;
  endtask

  task automatic core_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    core_address   = a;
    core_writedata = d;
    core_writemask = m;
  endtask

  // Drive a loader request; when the block is in LOADER the ack is due next cycle.
  task automatic ld_write(input logic [31:0] a, input logic [31:0] d, input logic granted);
    ld_req       = 1'b1;
    ld_address   = a;
    ld_writedata = d;
    ld_writemask = 4'hF;
    if (granted) ack_q.push_back(cycle_no + 1);
  endtask

  task automatic advance();
    logic exp_ack;
    exp_ack = (ack_q.size() > 0) && (ack_q[0] == cycle_no);
    if (exp_ack) void'(ack_q.pop_front());
    chk("ld_ack", {31'd0, ld_ack}, {31'd0, exp_ack});
    @(posedge clock);
    @(negedge clock);
    cycle_no++;
  endtask

  initial begin
    reset = 1'b1;
    ld_address = 32'h0;
    ld_writedata = 32'h0;
    idle_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    cycle_no = 0;

    // Cycle 0: reset state and core pass-through.
    core_store(32'h100, 32'hDEADBEEF, 4'hF);
    #1;
    chk_ctl(1'b0, 1'b0, 1'b0, 32'h0);
    chk_mem(32'h100, 32'hDEADBEEF, 4'hF);
    advance();

    // Cycles 1..9: idle core, with a stray release at cycle 3.
    while (cycle_no < 10) begin
      idle_inputs();
      if (cycle_no == 3) begin
        ld_release    = 1'b1;
        ld_restart_pc = 32'h0000_0BAD;
      end
      #1;
      chk_ctl(1'b0, 1'b0, 1'b0, 32'h0);
      advance();
    end

    // Cycle 10: loader request alongside a core store.
    idle_inputs();
    core_store(32'h200, 32'h12345678, 4'h3);
    ld_write(32'h300, 32'hA5A5_0300, 1'b0);
    #1;
    chk_mem(32'h200, 32'h12345678, 4'h3);
    chk_ctl(1'b0, 1'b0, 1'b0, 32'h0);
    advance();

    // Cycles 11..13: DRAIN, loader holds its request, core stores still pass.
    while (cycle_no < 14) begin
      core_store(32'h204 + 32'(cycle_no), 32'hC0DE_0000 + 32'(cycle_no), 4'hF);
      ld_release    = (cycle_no == 12);
      ld_restart_pc = 32'h0000_0BAD;
      #1;
      chk_ctl(1'b1, 1'b0, 1'b0, 32'h0);
      chk_mem(32'h204 + 32'(cycle_no), 32'hC0DE_0000 + 32'(cycle_no), 4'hF);
      advance();
    end

    // Cycle 14: LOADER entry; the held request is written.
    ld_release = 1'b0;
    core_store(32'h999, 32'h9999_9999, 4'hF);
    ld_write(32'h300, 32'hA5A5_0300, 1'b1);
    #1;
    chk_ctl(1'b1, 1'b0, 1'b1, 32'h0);
    chk_mem(32'h300, 32'hA5A5_0300, 4'hF);
    advance();

    // Cycles 15..18: four back-to-back loader writes.
    for (int i = 0; i < 4; i++) begin
      ld_write(32'(4 * i), 32'h1000_0000 + 32'(i), 1'b1);
      #1;
      chk_ctl(1'b1, 1'b0, 1'b1, 32'h0);
      chk_mem(32'(4 * i), 32'h1000_0000 + 32'(i), 4'hF);
      advance();
    end

    // Cycle 19: loader idle; port quiet even though the core drives a store.
    ld_req = 1'b0;
    #1;
    chk_ctl(1'b1, 1'b0, 1'b1, 32'h0);
    chk_mem(32'h0, 32'h0, 4'h0);
    advance();

    // Cycle 20: final write together with release.
    ld_write(32'h10, 32'h2000_0010, 1'b1);
    ld_release    = 1'b1;
    ld_restart_pc = 32'h80;
    #1;
    chk_ctl(1'b1, 1'b0, 1'b1, 32'h0);
    chk_mem(32'h10, 32'h2000_0010, 4'hF);
    advance();

    // Cycle 21: RESUME; a new request here must not be serviced.
    ld_release    = 1'b0;
    ld_restart_pc = 32'h0;
    ld_write(32'h20, 32'h3000_0020, 1'b0);
    #1;
    chk_ctl(1'b1, 1'b1, 1'b0, 32'h80);
    chk_mem(32'h0, 32'h0, 4'h0);
    advance();

    // Cycle 22: back in CORE; the still-held request starts a new drain.
    core_store(32'h404, 32'h4444_0404, 4'hC);
    #1;
    chk_ctl(1'b0, 1'b0, 1'b0, 32'h80);
    chk_mem(32'h404, 32'h4444_0404, 4'hC);
    advance();

    // Cycles 23..25: second DRAIN.
    while (cycle_no < 26) begin
      #1;
      chk_ctl(1'b1, 1'b0, 1'b0, 32'h80);
      advance();
    end

    // Cycle 26: second LOADER entry.
    ld_write(32'h20, 32'h3000_0020, 1'b1);
    #1;
    chk_ctl(1'b1, 1'b0, 1'b1, 32'h80);
    chk_mem(32'h20, 32'h3000_0020, 4'hF);
    advance();

    // Cycle 27: reset in LOADER with a live request; no ack may follow.
    ld_write(32'h24, 32'h3000_0024, 1'b0);
    core_store(32'h400, 32'h5555_0400, 4'hF);
    reset = 1'b1;
    #1;
    chk_mem(32'h24, 32'h3000_0024, 4'hF);
    advance();

    // Cycle 28: everything back to reset values, core owns the port.
    reset = 1'b0;
    #1;
    chk_ctl(1'b0, 1'b0, 1'b0, 32'h0);
    chk_mem(32'h400, 32'h5555_0400, 4'hF);
    advance();

    // Cycle 29: request held after reset begins a fresh drain.
    #1;
    chk_ctl(1'b1, 1'b0, 1'b0, 32'h0);
    advance();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
